// File: rtl/majority_bist_ctrl.sv
// BIST sequencer for majority_circuit: sweeps all input vectors and checks against a popcount model.
// Optional build macro MAJ_BIST_STOP_ON_ERR_EN ends the sweep on the first mismatch.
module majority_bist_ctrl #(
  parameter int unsigned WIDTH_IN = 5,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  output logic [WIDTH_IN-1:0] seq_o,
  input  logic                maj_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [ERR_W-1:0]    err_cnt_o,
  output logic [WIDTH_IN-1:0] first_err_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH_IN + 1);
  localparam int unsigned HALF  = WIDTH_IN / 2 + 1;
  localparam logic [WIDTH_IN-1:0] SEQ_LAST = '1;
  localparam logic [ERR_W-1:0]    ERR_MAX  = '1;
`ifdef MAJ_BIST_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_err_seen;
  logic [CNT_W-1:0]   w_pop;
  logic               w_gold;
  logic               w_mismatch;
  logic [ERR_W-1:0]   w_err_nxt;
  logic               w_last;

  // Golden model: popcount of the presented vector against the majority threshold
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(WIDTH_IN); i++) begin
      w_pop = w_pop + CNT_W'(seq_o[i]);
    end
  end

  assign w_gold     = (w_pop >= CNT_W'(HALF));
  assign w_mismatch = (maj_i != w_gold);
  assign w_err_nxt  = (w_mismatch && (err_cnt_o != ERR_MAX)) ? err_cnt_o + ERR_W'(1) : err_cnt_o;
  assign w_last     = (seq_o == SEQ_LAST) || (STOP_ON_ERR && w_mismatch);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_err_seen  <= 1'b0;
      seq_o       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      err_cnt_o   <= '0;
      first_err_o <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          err_cnt_o <= w_err_nxt;
          if (w_mismatch && !r_err_seen) begin
            first_err_o <= seq_o;
            r_err_seen  <= 1'b1;
          end
          // Final vector (or first failure when stopping early) is scored on the exit edge
          if (w_last) begin
            r_state <= ST_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            pass_o  <= (w_err_nxt == '0);
          end else begin
            seq_o <= seq_o + WIDTH_IN'(1);
          end
        end
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_state     <= ST_RUN;
            r_err_seen  <= 1'b0;
            seq_o       <= '0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            err_cnt_o   <= '0;
            first_err_o <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          pass_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_majority_bist_ctrl.sv
// Directed bench for majority_bist_ctrl with a behavioural majority_circuit in correct/inverted/stuck-0 modes.
// Expectations follow MAJ_BIST_STOP_ON_ERR_EN when the bench is built with that macro.
module tb_majority_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] seq;
  logic       maj;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [4:0] first_err;
  logic [4:0] seq4;
  logic       maj4;
  logic       busy4, done4, pass4;
  logic [3:0] err_cnt4;
  logic [4:0] first_err4;
  int         mode;
  int         n_cmp = 0;
  int         n_mis = 0;
  int         n;

  always #5 clk = ~clk;

  function automatic logic maj_ref(input logic [4:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 5; i++) c += int'(v[i]);
    return (c >= 3);
  endfunction

  // Device under BIST: 0 correct, 1 inverted, 2 stuck-at-0
  always_comb begin
    case (mode)
      1:       maj = ~maj_ref(seq);
      2:       maj = 1'b0;
      default: maj = maj_ref(seq);
    endcase
  end
  assign maj4 = ~maj_ref(seq4);

  majority_bist_ctrl #(.WIDTH_IN(5), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .seq_o(seq), .maj_i(maj),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt), .first_err_o(first_err)
  );

  majority_bist_ctrl #(.WIDTH_IN(5), .ERR_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .seq_o(seq4), .maj_i(maj4),
    .busy_o(busy4), .done_o(done4), .pass_o(pass4), .err_cnt_o(err_cnt4), .first_err_o(first_err4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then count RUN cycles until busy drops; start is re-pulsed at cycle inj
  task automatic sweep(input int inj, output int cycles);
    start = 1'b1;
    step();
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      start = (cycles == inj);
      step();
      cycles++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    step();
    step();
    check("rst_seq", 32'(seq), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pass", 32'(pass), 32'h0);
    check("rst_err", 32'(err_cnt), 32'h0);
    check("rst_first", 32'(first_err), 32'h0);
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'h0);

    // Correct DUT
    sweep(-1, n);
    check("ok_cycles", 32'(n), 32'd32);
    check("ok_done", 32'(done), 32'h1);
    check("ok_pass", 32'(pass), 32'h1);
    check("ok_err", 32'(err_cnt), 32'h0);
    check("ok_first", 32'(first_err), 32'h0);
    check("ok_seq", 32'(seq), 32'h1F);
    step();
    check("ok_hold_done", 32'(done), 32'h1);
    check("ok_hold_seq", 32'(seq), 32'h1F);

    // Inverted DUT, also drives the ERR_W=4 instance
    mode = 1;
    sweep(-1, n);
    check("inv_done", 32'(done), 32'h1);
    check("inv_pass", 32'(pass), 32'h0);
    check("inv_first", 32'(first_err), 32'h0);
`ifdef MAJ_BIST_STOP_ON_ERR_EN
    check("inv_cycles", 32'(n), 32'd1);
    check("inv_err", 32'(err_cnt), 32'd1);
    check("inv_seq", 32'(seq), 32'h0);
`else
    check("inv_cycles", 32'(n), 32'd32);
    check("inv_err", 32'(err_cnt), 32'd32);
    check("w4_err", 32'(err_cnt4), 32'd15);
    check("w4_pass", 32'(pass4), 32'h0);
    check("w4_done", 32'(done4), 32'h1);
`endif

    // Stuck-at-0 DUT
    mode = 2;
    sweep(-1, n);
    check("sa0_done", 32'(done), 32'h1);
    check("sa0_pass", 32'(pass), 32'h0);
    check("sa0_first", 32'(first_err), 32'h07);
`ifdef MAJ_BIST_STOP_ON_ERR_EN
    check("sa0_cycles", 32'(n), 32'd8);
    check("sa0_err", 32'(err_cnt), 32'd1);
    check("sa0_seq", 32'(seq), 32'h07);
`else
    check("sa0_cycles", 32'(n), 32'd32);
    check("sa0_err", 32'(err_cnt), 32'd16);
    check("sa0_seq", 32'(seq), 32'h1F);
`endif

    // Reset mid-RUN at seq_o=10
    mode  = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (seq != 5'd10 && n < 100) begin
      step();
      n++;
    end
    check("mid_reached10", 32'(seq), 32'd10);
    rst_n = 1'b0;
    step();
    check("mid_rst_seq", 32'(seq), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_err", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;
    step();
    step();
    check("mid_idle_busy", 32'(busy), 32'h0);
    check("mid_idle_done", 32'(done), 32'h0);

    // Clean sweep with a start pulse injected mid-RUN
    sweep(5, n);
    check("re_cycles", 32'(n), 32'd32);
    check("re_done", 32'(done), 32'h1);
    check("re_pass", 32'(pass), 32'h1);
    check("re_err", 32'(err_cnt), 32'h0);
    check("re_seq", 32'(seq), 32'h1F);

    // Held start: DONE lasts one cycle, then an immediate restart
    start = 1'b1;
    step();
    check("hold_run", 32'(busy), 32'h1);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check("hold_cycles", 32'(n), 32'd32);
    check("hold_done", 32'(done), 32'h1);
    step();
    check("hold_restart", 32'(busy), 32'h1);
    check("hold_seq0", 32'(seq), 32'h0);
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
